apb_memif_demux: RTL and testbench
==================================

// Module: apb_memif_demux
// PURPOSE
// APB slave that decodes each transfer into one of NUM_SLV memory-interface channels by address region.
// Successor to the single-channel APB memory bridge, with three additions:
// per-channel request/ack, a decode error for unmapped addresses, and a wait-state timeout.
// Sits between the APB fabric and a cluster of memory-mapped peripherals/RAMs.
// All APB response outputs are registered.
// PARAMETERS
// ADDR_WIDTH      32  APB address width
// DATA_WIDTH      32  data width; strobe width = DATA_WIDTH/8
// NUM_SLV         4   number of memory channels (>=1)
// SLV_ADDR_WIDTH  12  per-channel region size = 2**SLV_ADDR_WIDTH bytes; also maddr_o width
// BASE_ADDR       0   base of channel 0; channel i base = BASE_ADDR + i*2**SLV_ADDR_WIDTH
// TIMEOUT         16  max wait cycles after mreq before error response; 0 disables the timeout
// PORTS
// clk_i      in   1                   clock
// arst_ni    in   1                   asynchronous reset, active low
// psel_i     in   1                   APB select
// penable_i  in   1                   APB enable
// paddr_i    in   ADDR_WIDTH          APB address
// pwrite_i   in   1                   APB write
// pwdata_i   in   DATA_WIDTH          APB write data
// pstrb_i    in   DATA_WIDTH/8        APB byte strobe
// pready_o   out  1                   APB ready (registered)
// prdata_o   out  DATA_WIDTH          APB read data (registered)
// pslverr_o  out  1                   APB slave error (registered)
// mreq_o     out  NUM_SLV             one-hot request pulse per channel
// maddr_o    out  SLV_ADDR_WIDTH      paddr_i[SLV_ADDR_WIDTH-1:0], shared by all channels, combinational
// mwe_o      out  1                   pwrite_i, shared, combinational
// mwdata_o   out  DATA_WIDTH          pwdata_i, shared, combinational
// mstrb_o    out  DATA_WIDTH/8        pstrb_i, shared, combinational
// mack_i     in   NUM_SLV             per-channel acknowledge
// mrdata_i   in   NUM_SLV*DATA_WIDTH  channel i read data at bits [i*DATA_WIDTH +: DATA_WIDTH]
// mresp_i    in   NUM_SLV             per-channel error response, valid with mack_i
// BEHAVIOUR
// - Reset: state=IDLE, timeout count=0, sel_q=0; pready_o=0, prdata_o=0, pslverr_o=0, mreq_o=0.
//   Reset asserted mid-transfer aborts the transfer immediately; no response is given.
// - Decode: off = paddr_i - BASE_ADDR; idx = off >> SLV_ADDR_WIDTH.
//   Mapped iff paddr_i >= BASE_ADDR and idx < NUM_SLV.
// - FSM state IDLE: on psel_i & penable_i:
//   * Unmapped: no mreq; go to RESP with err=1, data=0.
//   * Mapped: mreq_o[idx]=1 in this cycle only (combinational); latch sel_q=idx, clear the counter.
//     If mack_i[idx] is high in the same cycle, go to RESP capturing mrdata/mresp of idx; else go to WAIT.
// - FSM state WAIT: mreq_o=0. Only mack_i[sel_q] is observed; acks on other channels are ignored.
//   * On mack_i[sel_q]: go to RESP; data = channel sel_q data, err = mresp_i[sel_q].
//   * Otherwise the counter increments each cycle. Call the mreq cycle 0.
//     An ack is accepted in cycles 0..TIMEOUT.
//     With no ack by cycle TIMEOUT, go to RESP with err=1, data=0 (ack in cycle TIMEOUT wins).
//     The counter is $clog2(TIMEOUT+1) bits, saturating.
// - FSM state RESP: one cycle only.
//   * pready_o=1; prdata_o = captured data, forced to 0 on writes; pslverr_o = captured err. Then IDLE.
//   * pready_o/prdata_o/pslverr_o are 0 in all other states.
// - Latency: pready_o rises the cycle after the accepted ack (min 1 cycle after mreq).
//   Decode or timeout errors respond the cycle after detection.
// - Acks in IDLE or RESP are ignored.
//   psel_i/penable_i dropping during WAIT (protocol violation): the transfer still completes.
//   In RESP, psel_i & penable_i are ignored (APB requires penable low after ready), so a held penable cannot re-issue.
// - No outstanding transfers: at most one channel request in flight.
// TESTING (defaults: NUM_SLV=4, SLV_ADDR_WIDTH=12, BASE_ADDR=0, TIMEOUT=16)
// 1 Read 0x2010, mack_i[2]=1 same cycle as mreq, data 0xDEADBEEF
//   -> mreq_o=4'b0100 for 1 cycle, maddr_o=0x010; next cycle pready_o=1, prdata_o=0xDEADBEEF, pslverr_o=0.
// 2 Write 0x0004, pwdata 0x12345678, pstrb 4'b0101, mack_i[0] 3 cycles after mreq
//   -> mwe_o=1, mstrb_o=4'b0101 forwarded; pready_o at cycle 4, prdata_o=0, pslverr_o=0.
// 3 Read 0x4000 (unmapped) -> mreq_o stays 0; pready_o=1, pslverr_o=1, prdata_o=0 the next cycle.
// 4 Read 0x3000, no ack -> pready_o=1, pslverr_o=1 at cycle 17.
//   Repeat with mack_i[3] at cycle 16 -> success at cycle 17, pslverr_o=0.
// 5 Read 0x3000; mack_i[1]=1 at cycle 2 (ignored); mack_i[3]=1, mresp_i[3]=1 at cycle 5
//   -> pready_o=1, pslverr_o=1 at cycle 6.
// 6 arst_ni low during WAIT -> all outputs 0, no pready_o; after release, access 0x1000 completes normally.

Source files
------------

// File: rtl/apb_memif_demux.sv
// APB slave that routes each transfer to one of NUM_SLV memory channels by address region,
// with a decode error for unmapped addresses, a wait-state timeout, and registered APB responses.
module apb_memif_demux #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLV        = 4,
  parameter int                    SLV_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT        = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]       pstrb_i,
  output logic                          pready_o,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          pslverr_o,
  output logic [NUM_SLV-1:0]            mreq_o,
  output logic [SLV_ADDR_WIDTH-1:0]     maddr_o,
  output logic                          mwe_o,
  output logic [DATA_WIDTH-1:0]         mwdata_o,
  output logic [DATA_WIDTH/8-1:0]       mstrb_o,
  input  logic [NUM_SLV-1:0]            mack_i,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] mrdata_i,
  input  logic [NUM_SLV-1:0]            mresp_i
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;

  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   region;
  logic                    mapped;
  logic [IDX_W-1:0]        idx;
  logic                    access;
  logic [DATA_WIDTH-1:0]   idx_rdata;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign off       = paddr_i - BASE_ADDR;
  assign region    = off >> SLV_ADDR_WIDTH;
  assign mapped    = (paddr_i >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLV));
  assign idx       = region[IDX_W-1:0];
  assign access    = psel_i & penable_i;
  assign idx_rdata = mrdata_i[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_rdata = mrdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

  assign maddr_o   = paddr_i[SLV_ADDR_WIDTH-1:0];
  assign mwe_o     = pwrite_i;
  assign mwdata_o  = pwdata_i;
  assign mstrb_o   = pstrb_i;

  assign pready_o  = pready_q;
  assign prdata_o  = prdata_q;
  assign pslverr_o = pslverr_q;

  // Response flops are loaded on the transition into RESP, so they are high exactly while in RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    we_d      = we_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    mreq_o    = '0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          we_d = pwrite_i;
          if (!mapped) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            mreq_o = NUM_SLV'(1) << idx;
            sel_d  = idx;
            cnt_d  = '0;
            if (mack_i[idx]) begin
              state_d   = S_RESP;
              pready_d  = 1'b1;
              prdata_d  = pwrite_i ? '0 : idx_rdata;
              pslverr_d = mresp_i[idx];
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (mack_i[sel_q]) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          prdata_d  = we_q ? '0 : sel_rdata;
          pslverr_d = mresp_i[sel_q];
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // cnt_q counts WAIT cycles from zero, so this is the last cycle an ack may arrive in
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_apb_memif_demux.sv
// Bench for apb_memif_demux: directed scenarios plus randomized transfers against a
// region/latency reference model; other channels see random ack noise throughout.
module tb_apb_memif_demux;

  localparam int  TIMEOUT = 16;
  localparam longint BASE = 0;

  logic         clk;
  logic         arst_n;
  logic         psel, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic [3:0]   mreq;
  logic [11:0]  maddr;
  logic         mwe;
  logic [31:0]  mwdata;
  logic [3:0]   mstrb;
  logic [3:0]   mack, mresp;
  logic [127:0] mrdata;

  int checks = 0;
  int errors = 0;

  apb_memif_demux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .SLV_ADDR_WIDTH(12),
    .BASE_ADDR(32'h0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .arst_ni(arst_n),
    .psel_i(psel), .penable_i(penable), .paddr_i(paddr), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
    .mreq_o(mreq), .maddr_o(maddr), .mwe_o(mwe), .mwdata_o(mwdata), .mstrb_o(mstrb),
    .mack_i(mack), .mrdata_i(mrdata), .mresp_i(mresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_mapped(input logic [31:0] a);
    longint off;
    off = longint'(a) - BASE;
    return (off >= 0) && (off / 4096 < 4);
  endfunction

  // One full APB transfer (setup + access). ack_cyc: cycle (mreq cycle = 0) at which the
  // target channel acks, or -1 for never. Expected outcome derived from the region/timeout rules.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int ack_cyc, input bit resp,
                      input logic [31:0] rdata, input string name);
    bit          mapped;
    int          ch;
    int          exp_cyc;
    logic [31:0] exp_data;
    bit          exp_err;
    logic [3:0]  exp_mreq;
    int          got;
    logic [31:0] got_data;
    logic        got_err;
    int          stray_mreq;
    mapped   = is_mapped(addr);
    ch       = mapped ? int'((longint'(addr) - BASE) / 4096) : -1;
    exp_mreq = '0;
    if (!mapped) begin
      exp_cyc = 1; exp_err = 1'b1; exp_data = '0;
    end else begin
      exp_mreq[ch] = 1'b1;
      if (ack_cyc >= 0 && ack_cyc <= TIMEOUT) begin
        exp_cyc = ack_cyc + 1; exp_err = resp; exp_data = wr ? 32'h0 : rdata;
      end else begin
        exp_cyc = TIMEOUT + 1; exp_err = 1'b1; exp_data = '0;
      end
    end
    got = -1; got_data = 'x; got_err = 1'bx; stray_mreq = 0;

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 40 && got < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      mack   = 4'($urandom);
      mresp  = 4'($urandom);
      mrdata = {$urandom, $urandom, $urandom, $urandom};
      if (mapped) begin
        mack[ch]  = (c == ack_cyc);
        mresp[ch] = resp;
        if (c == ack_cyc) mrdata[ch*32 +: 32] = rdata;
      end
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (mreq !== exp_mreq) begin
          errors++;
          $display("FAIL %s mreq: got %b expected %b", name, mreq, exp_mreq);
        end
        checks++;
        if ({maddr, mwe, mwdata, mstrb} !== {addr[11:0], wr, wdata, strb}) begin
          errors++;
          $display("FAIL %s fwd: got maddr=%h mwe=%b mwdata=%h mstrb=%b expected %h %b %h %b",
                   name, maddr, mwe, mwdata, mstrb, addr[11:0], wr, wdata, strb);
        end
      end else if (mreq !== 4'b0) begin
        stray_mreq++;
      end
      if (pready === 1'b1) begin
        got = c; got_data = prdata; got_err = pslverr;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; mack = '0; mresp = '0;
    @(negedge clk);

    checks++;
    if (got !== exp_cyc) begin
      errors++;
      $display("FAIL %s resp_cycle: got %0d expected %0d", name, got, exp_cyc);
    end
    checks++;
    if (got_data !== exp_data) begin
      errors++;
      $display("FAIL %s prdata: got %h expected %h", name, got_data, exp_data);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++;
      $display("FAIL %s pslverr: got %b expected %b", name, got_err, exp_err);
    end
    checks++;
    if (stray_mreq !== 0) begin
      errors++;
      $display("FAIL %s mreq_pulse: got %0d extra mreq cycles expected 0", name, stray_mreq);
    end
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      errors++;
      $display("FAIL %s resp_one_cycle: got pready=%b pslverr=%b prdata=%h expected 0",
               name, pready, pslverr, prdata);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    mack = '0; mresp = '0; mrdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pready, pslverr, prdata, mreq} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h mreq=%b expected all 0",
               pready, pslverr, prdata, mreq);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_read_same_cycle();
    xfer(32'h2010, 1'b0, 32'h0, 4'hf, 0, 1'b0, 32'hDEADBEEF, "read_same_cycle");
  endtask

  task automatic test_write_wait();
    xfer(32'h0004, 1'b1, 32'h12345678, 4'b0101, 3, 1'b0, 32'hCAFEF00D, "write_wait");
  endtask

  task automatic test_unmapped();
    xfer(32'h4000, 1'b0, 32'h0, 4'hf, 0, 1'b0, 32'h11111111, "unmapped");
    xfer(32'hFFFF_FFFC, 1'b1, 32'h5, 4'hf, 0, 1'b0, 32'h0, "unmapped_top");
  endtask

  task automatic test_timeout();
    xfer(32'h3000, 1'b0, 32'h0, 4'hf, -1, 1'b0, 32'h0, "timeout_noack");
    xfer(32'h3000, 1'b0, 32'h0, 4'hf, TIMEOUT, 1'b0, 32'hA5A5_5A5A, "timeout_last_ack");
    xfer(32'h3000, 1'b0, 32'h0, 4'hf, TIMEOUT + 1, 1'b0, 32'h1234, "timeout_late_ack");
  endtask

  task automatic test_wrong_channel();
    xfer(32'h3000, 1'b0, 32'h0, 4'hf, 5, 1'b1, 32'h0BAD_0BAD, "ack_error_resp");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h3000; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; mack = '0;
    repeat (3) @(posedge clk);
    #2;
    arst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata, mreq} !== 38'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got pready=%b pslverr=%b prdata=%h mreq=%b expected 0",
               pready, pslverr, prdata, mreq);
    end
    repeat (2) @(posedge clk);
    mack = 4'b1000;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_ready: got %b expected 0", pready);
    end
    arst_n = 1'b1;
    @(posedge clk); #1;
    mack = '0;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after_release: got pready=%b expected 0", pready);
    end
    xfer(32'h1000, 1'b0, 32'h0, 4'hf, 2, 1'b0, 32'h600D_1000, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          ack;
      a   = (32'($urandom_range(0, 5)) << 12) | (32'($urandom) & 32'hFFC);
      ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 3));
      xfer(a, 1'($urandom), $urandom, 4'($urandom), ack, 1'($urandom), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    xfer(32'h0FFC, 1'b0, 32'h0, 4'hf, 0, 1'b0, 32'h0000_0FFC, "b2b_ch0_top");
    xfer(32'h1000, 1'b1, 32'h77, 4'h1, 0, 1'b1, 32'h0, "b2b_ch1_err");
    xfer(32'h3FFC, 1'b0, 32'h0, 4'hf, 1, 1'b0, 32'h3FFC_3FFC, "b2b_ch3_top");
  endtask

  initial begin
    test_reset();
    test_read_same_cycle();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_wrong_channel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
